// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared FSM states, space code and code-word field offsets for the Morse frame assembler
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WORD_WAIT
    } morse_state_t;

    // The code-to-ASCII ROM maps an all-zero code word to a space.
    localparam logic [31:0] SPACE_CODE = 32'd0;

    function automatic int pattern_lsb();
        return 0;
    endfunction

    function automatic int count_lsb(input int max_symbols);
        return max_symbols;
    endfunction

    function automatic int error_bit(input int max_symbols, input int cnt_w);
        return max_symbols + cnt_w;
    endfunction

endpackage

// File: rtl/morse_frame_assembler_if.sv
// rtl/morse_frame_assembler_if.sv - valid/ready code-word stream between the assembler and its consumer
interface morse_frame_assembler_if #(
    parameter int CODE_W = 10
);
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code_data;

    modport master (
        output code_valid,
        output code_data,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code_data,
        output code_ready
    );
endinterface

// File: rtl/morse_code_fifo.sv
// rtl/morse_code_fifo.sv - show-ahead synchronous FIFO holding completed code words
module morse_code_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot the push lands in, so a full FIFO still accepts it.
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/morse_frame_assembler.sv
// rtl/morse_frame_assembler.sv - times key presses/gaps into Morse letters and queues code words; MORSE_AUTO_SPACE_EN adds word-space entries
module morse_frame_assembler
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS  = 6,
    parameter int UNIT_CYCLES  = 5_000_000,
    parameter int DASH_UNITS   = 2,
    parameter int LETTER_UNITS = 2,
    parameter int WORD_UNITS   = 6,
    parameter int FIFO_DEPTH   = 4,
    localparam int CNT_W       = $clog2(MAX_SYMBOLS + 1),
    localparam int CODE_W      = 1 + CNT_W + MAX_SYMBOLS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    b,
    input  logic                    clr_ovf,
    morse_frame_assembler_if.master code_if,
    output logic [MAX_SYMBOLS-1:0]  live_pattern,
    output logic [CNT_W-1:0]        live_count,
    output logic                    overflow
);
    localparam int PCNT_W  = $clog2(UNIT_CYCLES);
    localparam int PAT_LSB = pattern_lsb();
    localparam int CNT_LSB = count_lsb(MAX_SYMBOLS);
    localparam int ERR_BIT = error_bit(MAX_SYMBOLS, CNT_W);

    morse_state_t      state, state_nx;
    logic              b_q;
    logic              rise, fall, b_edge;
    logic [PCNT_W-1:0] pcnt;
    logic              pcnt_last, tick;
    logic [2:0]        dur;
    logic              letter_err;
    logic              append, push_letter, push_space;
    logic [CODE_W-1:0] letter_word, fifo_wdata;
    logic              fifo_full, fifo_empty, fifo_drop;

    assign rise      = b & ~b_q;
    assign fall      = ~b & b_q;
    assign b_edge    = rise | fall;
    assign pcnt_last = (pcnt == PCNT_W'(UNIT_CYCLES - 1));
    // An edge restarts timing, so a tick landing on the edge cycle is discarded.
    assign tick      = pcnt_last & ~b_edge;

    always_comb begin
        letter_word = '0;
        letter_word[PAT_LSB +: MAX_SYMBOLS] = live_pattern;
        letter_word[CNT_LSB +: CNT_W]       = live_count;
        letter_word[ERR_BIT]                = letter_err;
    end

    always_comb begin
        state_nx    = state;
        append      = 1'b0;
        push_letter = 1'b0;
        push_space  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nx = PRESS;
            end
            PRESS: begin
                if (fall) begin
                    append   = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (dur >= 3'(LETTER_UNITS)) begin
                    push_letter = 1'b1;
                    state_nx    = rise ? PRESS : WORD_WAIT;
                end else if (rise) begin
                    state_nx = PRESS;
                end
            end
            WORD_WAIT: begin
                if (dur >= 3'(WORD_UNITS)) begin
`ifdef MORSE_AUTO_SPACE_EN
                    push_space = 1'b1;
`else
                    push_space = 1'b0;
`endif
                    state_nx   = rise ? PRESS : IDLE;
                end else if (rise) begin
                    state_nx = PRESS;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fifo_wdata = push_letter ? letter_word : CODE_W'(SPACE_CODE);
    assign fifo_drop  = (push_letter | push_space) & fifo_full
                        & ~(code_if.code_ready & ~fifo_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            b_q          <= 1'b0;
            pcnt         <= '0;
            dur          <= '0;
            live_pattern <= '0;
            live_count   <= '0;
            letter_err   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state <= state_nx;
            b_q   <= b;

            if (b_edge || pcnt_last) pcnt <= '0;
            else                     pcnt <= pcnt + 1'b1;

            if (b_edge)                   dur <= '0;
            else if (tick && dur != 3'd7) dur <= dur + 3'd1;

            if (push_letter) begin
                live_pattern <= '0;
                live_count   <= '0;
                letter_err   <= 1'b0;
            end else if (append) begin
                // An overrun element only flags the letter; earlier elements are kept.
                if (live_count == CNT_W'(MAX_SYMBOLS)) begin
                    letter_err <= 1'b1;
                end else begin
                    live_pattern <= {live_pattern[MAX_SYMBOLS-2:0], (dur >= 3'(DASH_UNITS))};
                    live_count   <= live_count + 1'b1;
                end
            end

            if (fifo_drop)    overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    morse_code_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_letter | push_space),
        .pop     (code_if.code_ready),
        .wr_data (fifo_wdata),
        .rd_data (code_if.code_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign code_if.code_valid = ~fifo_empty;
endmodule

// File: tb/tb_morse_frame_assembler.sv
// tb/tb_morse_frame_assembler.sv - self-checking bench for morse_frame_assembler against a timing-rule model
module tb_morse_frame_assembler;
    localparam int MAX_SYMBOLS = 6;
    localparam int UNIT        = 4;
    localparam int DASH_U      = 2;
    localparam int LETTER_U    = 2;
    localparam int WORD_U      = 6;
    localparam int DEPTH       = 4;
    localparam int CNT_W       = 3;
    localparam int CODE_W      = 10;
`ifdef MORSE_AUTO_SPACE_EN
    localparam bit AUTO_SPACE = 1'b1;
`else
    localparam bit AUTO_SPACE = 1'b0;
`endif

    localparam logic [CODE_W-1:0] W_E   = 10'b0_001_000000;
    localparam logic [CODE_W-1:0] W_T   = 10'b0_001_000001;
    localparam logic [CODE_W-1:0] W_I   = 10'b0_010_000000;
    localparam logic [CODE_W-1:0] W_A   = 10'b0_010_000001;
    localparam logic [CODE_W-1:0] W_OVR = 10'b1_110_000000;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic b = 1'b0;
    logic clr_ovf = 1'b0;
    logic [MAX_SYMBOLS-1:0] live_pattern;
    logic [CNT_W-1:0]       live_count;
    logic                   overflow;

    morse_frame_assembler_if #(.CODE_W(CODE_W)) code_if ();

    morse_frame_assembler #(
        .MAX_SYMBOLS  (MAX_SYMBOLS),
        .UNIT_CYCLES  (UNIT),
        .DASH_UNITS   (DASH_U),
        .LETTER_UNITS (LETTER_U),
        .WORD_UNITS   (WORD_U),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .b            (b),
        .clr_ovf      (clr_ovf),
        .code_if      (code_if),
        .live_pattern (live_pattern),
        .live_count   (live_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int rdy_pct = 100;

    // Model: letters are derived from edge times; a press lasting L cycles
    // is worth (L-1)/UNIT units, a letter closes LETTER_U*UNIT+1 cycles after release.
    bit                m_b_prev = 1'b0;
    int                last_rise = 0;
    int                last_fall = 0;
    bit                elems[$];
    bit                m_err = 1'b0;
    bit                word_armed = 1'b0;
    logic [CODE_W-1:0] mq[$];
    bit                m_ovf = 1'b0;
    logic [CODE_W-1:0] popped[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [MAX_SYMBOLS-1:0] model_pattern();
        int unsigned p = 0;
        for (int i = 0; i < elems.size(); i++)
            if (elems[i]) p += 32'd1 << (elems.size() - 1 - i);
        return MAX_SYMBOLS'(p);
    endfunction

    task automatic model_reset();
        m_b_prev = 1'b0;
        elems.delete();
        m_err = 1'b0;
        word_armed = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_compare();
        check("code_valid", 32'(code_if.code_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check("code_data", 32'(code_if.code_data), 32'(mq[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("live_count", 32'(live_count), 32'(elems.size()));
        check("live_pattern", 32'(live_pattern), 32'(model_pattern()));
    endtask

    task automatic model_step();
        bit pop_now, full_now, push_now, drop_now;
        logic [CODE_W-1:0] push_word;
        pop_now   = (mq.size() > 0) && code_if.code_ready;
        full_now  = (mq.size() == DEPTH);
        push_now  = 1'b0;
        push_word = '0;
        if (!m_b_prev && elems.size() > 0 && cyc == last_fall + LETTER_U * UNIT + 1) begin
            push_now   = 1'b1;
            push_word  = {m_err, CNT_W'(elems.size()), model_pattern()};
            elems.delete();
            m_err      = 1'b0;
            word_armed = 1'b1;
        end else if (!m_b_prev && word_armed && cyc == last_fall + WORD_U * UNIT + 1) begin
            word_armed = 1'b0;
            push_now   = AUTO_SPACE;
        end
        if (b && !m_b_prev) begin
            last_rise  = cyc;
            word_armed = 1'b0;
        end
        if (!b && m_b_prev) begin
            if (elems.size() == MAX_SYMBOLS) m_err = 1'b1;
            else elems.push_back(((cyc - last_rise - 1) / UNIT) >= DASH_U);
            last_fall = cyc;
        end
        drop_now = push_now && full_now && !pop_now;
        if (pop_now) void'(mq.pop_front());
        if (push_now && !drop_now) mq.push_back(push_word);
        if (drop_now) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        m_b_prev = b;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
            model_compare();
        end else begin
            model_compare();
            if (code_if.code_valid && code_if.code_ready) popped.push_back(code_if.code_data);
            model_step();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input int press, input int gap);
        b = 1'b1;
        step(press);
        b = 1'b0;
        step(gap);
    endtask

    task automatic rstep(input int n);
        repeat (n) begin
            code_if.code_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            clr_ovf = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        b = 1'b0;
        clr_ovf = 1'b0;
        code_if.code_ready = 1'b0;
        step(2);
        reset_n = 1'b1;
        popped.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(code_if.code_valid), 32'd0);
        check({tag, "_data"}, 32'(code_if.code_data), 32'd0);
        check({tag, "_count"}, 32'(live_count), 32'd0);
        check({tag, "_pattern"}, 32'(live_pattern), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        code_if.code_ready = 1'b0;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset");

        // Letter A: dot, dash, then a letter gap; push lands 1 cycle after the dur=2 tick
        do_reset();
        key(UNIT, UNIT);
        b = 1'b1;
        step(3 * UNIT);
        b = 1'b0;
        step(9);
        check("A_not_yet", 32'(code_if.code_valid), 32'd0);
        step(1);
        check("A_valid", 32'(code_if.code_valid), 32'd1);
        check("A_word", 32'(code_if.code_data), 32'(W_A));
        check("A_live_count", 32'(live_count), 32'd0);
        step(2);

        // Word gap after E
        do_reset();
        code_if.code_ready = 1'b1;
        key(UNIT, 7 * UNIT);
        check("word_entries", 32'(popped.size()), 32'(AUTO_SPACE ? 2 : 1));
        check("word_first", 32'(popped[0]), 32'(W_E));
        check("word_last", 32'(popped[popped.size() - 1]), 32'(AUTO_SPACE ? 10'h000 : W_E));

        // Overrun: seven dots in one letter
        do_reset();
        code_if.code_ready = 1'b1;
        repeat (6) key(UNIT, UNIT);
        key(UNIT, 3 * UNIT);
        check("ovr_entries", 32'(popped.size()), 32'd1);
        check("ovr_word", 32'(popped[0]), 32'(W_OVR));

        // FIFO full: E T I A then N is dropped
        do_reset();
        key(UNIT, 3 * UNIT);
        key(3 * UNIT, 3 * UNIT);
        key(UNIT, UNIT);
        key(UNIT, 3 * UNIT);
        key(UNIT, UNIT);
        key(3 * UNIT, 3 * UNIT);
        key(3 * UNIT, UNIT);
        key(UNIT, 10);
        check("full_valid", 32'(code_if.code_valid), 32'd1);
        check("full_overflow", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        code_if.code_ready = 1'b1;
        step(4);
        code_if.code_ready = 1'b0;
        check("drain_count", 32'(popped.size()), 32'd4);
        check("drain_0", 32'(popped[0]), 32'(W_E));
        check("drain_1", 32'(popped[1]), 32'(W_T));
        check("drain_2", 32'(popped[2]), 32'(W_I));
        check("drain_3", 32'(popped[3]), 32'(W_A));
        check("drain_empty", 32'(code_if.code_valid), 32'd0);

        // Reset during a press clears everything at once
        do_reset();
        key(UNIT, 3 * UNIT);
        key(UNIT, UNIT);
        b = 1'b1;
        step(UNIT);
        check("pre_rst_valid", 32'(code_if.code_valid), 32'd1);
        check("pre_rst_count", 32'(live_count), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        b = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        key(3 * UNIT, 3 * UNIT);
        check("T_valid", 32'(code_if.code_valid), 32'd1);
        check("T_word", 32'(code_if.code_data), 32'(W_T));

        // Rising edge on the cycle the prescaler would tick
        do_reset();
        step(3);
        key(2 * UNIT, 3 * UNIT);
        check("coll_valid", 32'(code_if.code_valid), 32'd1);
        check("coll_word", 32'(code_if.code_data), 32'(W_E));

        // Randomised keying with random back-pressure and overflow clears
        do_reset();
        for (int it = 0; it < 200; it++) begin
            rdy_pct = int'($urandom_range(0, 100));
            if ($urandom_range(0, 4) == 0) rdy_pct = 0;
            b = 1'b1;
            rstep(int'($urandom_range(1, 14)));
            b = 1'b0;
            rstep(int'($urandom_range(1, 32)));
        end
        rdy_pct = 100;
        rstep(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
